video_pll_supervisor: RTL



---
 rtl/video_pll_supervisor.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/video_pll_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : video_pll_supervisor
// Description : Drives the video PLL reset, watches its lock output and
//               releases a clean reset to the VGA pixel pipeline. Sequences
//               reset -> lock wait -> stability window -> run, with lock
//               timeout/retry, lock-loss recovery and a hard-fail flag.
//               Optional macro LOCK_GLITCH_FILTER_EN adds a lock-drop filter
//               of GLITCH_CYCLES cycles while in RUN.
// Revision    : 1.0 - initial release
// ============================================================================
module video_pll_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int GLITCH_CYCLES = 4,
    parameter int CNT_W         = 8,
    localparam int RETRY_W      = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pll_locked,
    input  logic               relock_req,
    output logic               pll_rst,
    output logic               video_reset_n,
    output logic               ready,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [CNT_W-1:0]   loss_count
);

    // Timer width covers every programmable interval the supervisor counts.
    localparam int c_TMAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int c_TMAX_B   = (STABLE_CYCLES > GLITCH_CYCLES) ? STABLE_CYCLES : GLITCH_CYCLES;
    localparam int c_TMAX     = (c_TMAX_A > c_TMAX_B) ? c_TMAX_A : c_TMAX_B;
    localparam int c_TIMER_W  = $clog2(c_TMAX + 1);

    localparam logic [c_TIMER_W-1:0] c_RST_LAST    = c_TIMER_W'(RST_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_LOCK_LAST   = c_TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [c_TIMER_W-1:0] c_STABLE_LAST = c_TIMER_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0]   c_RETRY_MAX   = RETRY_W'(MAX_RETRIES);
    localparam logic [CNT_W-1:0]     c_LOSS_SAT    = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [c_TIMER_W-1:0]   r_timer;
    logic [c_TIMER_W-1:0]   w_timer_next;
    logic [RETRY_W-1:0]     r_retry_cnt;
    logic [RETRY_W-1:0]     w_retry_next;
    logic [CNT_W-1:0]       r_loss_count;
    logic [CNT_W-1:0]       w_loss_next;
    logic                   r_sync1;
    logic                   r_locked_s;
    logic                   r_pll_rst;
    logic                   r_video_reset_n;
    logic                   r_ready;
    logic                   r_fail;
    logic                   w_lock_lost;

    // Two-flop synchronizer for the asynchronous PLL lock indication.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1    <= 1'b0;
            r_locked_s <= 1'b0;
        end else begin
            r_sync1    <= pll_locked;
            r_locked_s <= r_sync1;
        end
    end

`ifdef LOCK_GLITCH_FILTER_EN
    localparam int c_GLITCH_W = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;
    localparam logic [c_GLITCH_W-1:0] c_GLITCH_LAST = c_GLITCH_W'(GLITCH_CYCLES - 1);

    logic [c_GLITCH_W-1:0] r_glitch_cnt;

    // A lock drop in RUN counts only once it has lasted GLITCH_CYCLES cycles.
    assign w_lock_lost = (r_state == ST_RUN) && !r_locked_s && (r_glitch_cnt == c_GLITCH_LAST);

    // Counts consecutive low lock cycles in RUN; any high cycle restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_glitch_cnt <= '0;
        end else if ((r_state == ST_RUN) && (w_state_next == ST_RUN) && !r_locked_s) begin
            r_glitch_cnt <= r_glitch_cnt + c_GLITCH_W'(1);
        end else begin
            r_glitch_cnt <= '0;
        end
    end
`else
    // Without the filter, a single low lock cycle in RUN is a lock loss.
    assign w_lock_lost = (r_state == ST_RUN) && !r_locked_s;
`endif

    // Sequencing decisions; relock_req overrides every other transition.
    always_comb begin
        w_state_next = r_state;
        w_retry_next = r_retry_cnt;
        w_loss_next  = r_loss_count;

        case (r_state)
            ST_RESET: begin
                if (r_timer == c_RST_LAST) begin
                    w_state_next = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (r_locked_s) begin
                    w_state_next = ST_STABLE;
                end else if (r_timer == c_LOCK_LAST) begin
                    if (r_retry_cnt == c_RETRY_MAX) begin
                        w_state_next = ST_FAIL;
                    end else begin
                        w_retry_next = r_retry_cnt + RETRY_W'(1);
                        w_state_next = ST_RESET;
                    end
                end
            end
            ST_STABLE: begin
                if (!r_locked_s) begin
                    w_state_next = ST_WAIT_LOCK;
                end else if (r_timer == c_STABLE_LAST) begin
                    w_state_next = ST_RUN;
                    w_retry_next = '0;
                end
            end
            ST_RUN: begin
                if (w_lock_lost) begin
                    if (r_loss_count != c_LOSS_SAT) begin
                        w_loss_next = r_loss_count + CNT_W'(1);
                    end
                    w_state_next = ST_RESET;
                end
            end
            ST_FAIL: begin
                w_state_next = ST_FAIL;
            end
            default: begin
                w_state_next = ST_RESET;
            end
        endcase

        // A lock loss seen on the same cycle is still counted above.
        if (relock_req) begin
            w_state_next = ST_RESET;
            w_retry_next = '0;
        end

        if ((w_state_next != r_state) || relock_req) begin
            w_timer_next = '0;
        end else begin
            w_timer_next = r_timer + c_TIMER_W'(1);
        end
    end

    // State, counters and registered outputs; outputs follow the next state
    // so they are aligned with the state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_RESET;
            r_timer         <= '0;
            r_retry_cnt     <= '0;
            r_loss_count    <= '0;
            r_pll_rst       <= 1'b1;
            r_video_reset_n <= 1'b0;
            r_ready         <= 1'b0;
            r_fail          <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_timer         <= w_timer_next;
            r_retry_cnt     <= w_retry_next;
            r_loss_count    <= w_loss_next;
            r_pll_rst       <= (w_state_next == ST_RESET) || (w_state_next == ST_FAIL);
            r_video_reset_n <= (w_state_next == ST_RUN);
            r_ready         <= (w_state_next == ST_RUN);
            r_fail          <= (w_state_next == ST_FAIL);
        end
    end

    assign pll_rst       = r_pll_rst;
    assign video_reset_n = r_video_reset_n;
    assign ready         = r_ready;
    assign fail          = r_fail;
    assign retry_cnt     = r_retry_cnt;
    assign loss_count    = r_loss_count;

endmodule
`default_nettype wire
